// File: rtl/emif_shim_rsp_buf.sv
// emif_shim_rsp_buf: credit-gated read-response buffer between a command
// source and an EMIF whose read-data beats cannot be stalled.
//   clk, rst            : clock, asynchronous active-high reset
//   cmd_in_*            : upstream command (valid/ready, read flag, burst)
//   cmd_out_valid/ready : command forwarded to the EMIF
//   emif_rdata_valid/_  : unstallable read beats from the EMIF
//   rsp_valid/data/ready: first-word-fall-through response stream
//   credits             : entries neither stored nor reserved by reads in flight
//   err_ovf, err_spur   : sticky overflow / unsolicited-beat flags
module emif_shim_rsp_buf #(
    parameter int unsigned P_WIDTH   = 10,
    parameter int unsigned P_DEPTH   = 16,
    parameter int unsigned P_BURST_W = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_in_valid,
    input  logic                         cmd_in_read,
    input  logic [P_BURST_W-1:0]         cmd_in_burst,
    output logic                         cmd_in_ready,
    output logic                         cmd_out_valid,
    input  logic                         cmd_out_ready,
    input  logic                         emif_rdata_valid,
    input  logic [P_WIDTH-1:0]           emif_rdata,
    output logic                         rsp_valid,
    output logic [P_WIDTH-1:0]           rsp_data,
    input  logic                         rsp_ready,
    output logic [$clog2(P_DEPTH):0]     credits,
    output logic                         err_ovf,
    output logic                         err_spur
);

    localparam int unsigned AW = $clog2(P_DEPTH);
    localparam int unsigned CW = AW + 1;
    // Common width wide enough for either the burst or the credit count.
    localparam int unsigned SW = ((CW > P_BURST_W) ? CW : P_BURST_W) + 1;

    logic [CW-1:0]        out_q;
    logic [CW-1:0]        occ_q;
    logic [AW-1:0]        rd_ptr;
    logic [AW-1:0]        wr_ptr;
    logic [P_WIDTH-1:0]   mem [P_DEPTH];

    logic [P_BURST_W-1:0] burst_eff;
    logic                 allow;
    logic                 acc;
    logic                 pop;
    logic                 push;
    logic                 dec;
    logic                 bypass;
    logic [CW-1:0]        out_nxt;
    logic [CW-1:0]        occ_nxt;

    // Credit check, handshakes and next counter values.
    always_comb begin
        burst_eff     = (cmd_in_burst == '0) ? P_BURST_W'(1) : cmd_in_burst;
        allow         = ~cmd_in_read | (SW'(burst_eff) <= SW'(credits));
        cmd_in_ready  = cmd_out_ready & allow & ~rst;
        cmd_out_valid = cmd_in_valid & allow & ~rst;
        acc           = cmd_in_valid & cmd_in_ready & cmd_in_read;
        pop           = rsp_valid & rsp_ready;
        push          = emif_rdata_valid & ((occ_q < CW'(P_DEPTH)) | pop);
        dec           = emif_rdata_valid & (out_q != '0);
        // Head register loads the incoming beat when it becomes the new head.
        bypass        = push & ((occ_q == '0) | (pop & (occ_q == CW'(1))));
        out_nxt       = out_q + (acc ? CW'(burst_eff) : '0) - (dec ? CW'(1) : '0);
        occ_nxt       = occ_q + CW'(push) - CW'(pop);
    end

    // Counters, pointers, status and error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q     <= '0;
            occ_q     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            rsp_valid <= 1'b0;
            credits   <= CW'(P_DEPTH);
            err_ovf   <= 1'b0;
            err_spur  <= 1'b0;
        end else begin
            out_q     <= out_nxt;
            occ_q     <= occ_nxt;
            rsp_valid <= (occ_nxt != '0);
            credits   <= CW'(P_DEPTH) - (out_nxt + occ_nxt);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (emif_rdata_valid & ~push)       err_ovf  <= 1'b1;
            if (emif_rdata_valid & ~dec)        err_spur <= 1'b1;
        end
    end

    // Beat storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= emif_rdata;
    end

    // Registered head of the FIFO, held while not popped.
    always_ff @(posedge clk) begin
        if (bypass)   rsp_data <= emif_rdata;
        else if (pop) rsp_data <= mem[rd_ptr + AW'(1)];
    end

endmodule

// File: tb/tb_emif_shim_rsp_buf.sv
// Scoreboard bench for emif_shim_rsp_buf: a queue-based reference model
// predicts stored beats and counters; a monitor checks every presented beat.
module tb_emif_shim_rsp_buf;

    localparam int unsigned W  = 10;
    localparam int unsigned D  = 16;
    localparam int unsigned BW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_in_valid, cmd_in_read, cmd_in_ready;
    logic [BW-1:0] cmd_in_burst;
    logic          cmd_out_valid, cmd_out_ready;
    logic          emif_rdata_valid;
    logic [W-1:0]  emif_rdata;
    logic          rsp_valid, rsp_ready;
    logic [W-1:0]  rsp_data;
    logic [4:0]    credits;
    logic          err_ovf, err_spur;

    emif_shim_rsp_buf #(.P_WIDTH(W), .P_DEPTH(D), .P_BURST_W(BW)) dut (
        .clk(clk), .rst(rst),
        .cmd_in_valid(cmd_in_valid), .cmd_in_read(cmd_in_read),
        .cmd_in_burst(cmd_in_burst), .cmd_in_ready(cmd_in_ready),
        .cmd_out_valid(cmd_out_valid), .cmd_out_ready(cmd_out_ready),
        .emif_rdata_valid(emif_rdata_valid), .emif_rdata(emif_rdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .credits(credits), .err_ovf(err_ovf), .err_spur(err_spur)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: expected stored beats, reserved reads, flags.
    logic [W-1:0] exp_q[$];
    int           m_out  = 0;
    int           m_occ  = 0;
    bit           m_ovf  = 0;
    bit           m_spur = 0;
    logic [W-1:0] first_beat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_valid_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                check("rsp_data", 64'(rsp_data), 64'(exp_q[0]));
                if (rsp_ready) exp_q.delete(0);
            end
        end
    end

    // Reference model: predicts handshakes, counters and flags each cycle.
    always @(negedge clk) begin
        int  exp_cred, beff;
        bit  allow, exp_rdy, acc, pop;
        #1;
        if (rst) begin
            exp_q.delete();
            m_out = 0; m_occ = 0; m_ovf = 0; m_spur = 0;
        end else begin
            exp_cred = D - (m_out + m_occ);
            beff     = (cmd_in_burst == 0) ? 1 : int'(cmd_in_burst);
            allow    = !cmd_in_read || (beff <= exp_cred);
            exp_rdy  = cmd_out_ready && allow;
            check("credits",       64'(credits),       64'(exp_cred));
            check("cmd_in_ready",  64'(cmd_in_ready),  64'(exp_rdy));
            check("cmd_out_valid", 64'(cmd_out_valid), 64'(cmd_in_valid && allow));
            check("rsp_valid",     64'(rsp_valid),     64'(m_occ != 0));
            check("err_ovf",       64'(err_ovf),       64'(m_ovf));
            check("err_spur",      64'(err_spur),      64'(m_spur));
            acc = cmd_in_valid && exp_rdy && cmd_in_read;
            pop = (m_occ > 0) && rsp_ready;
            if (emif_rdata_valid) begin
                if (m_out > 0) m_out--; else m_spur = 1;
                if (m_occ < D || pop) begin
                    exp_q.push_back(emif_rdata);
                    m_occ++;
                end else begin
                    m_ovf = 1;
                end
            end
            if (acc) m_out += beff;
            if (pop) m_occ--;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_cmd(input bit rd, input int b, input int budget);
        bit got = 0;
        cmd_in_valid = 1; cmd_in_read = rd; cmd_in_burst = BW'(b);
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            got = cmd_in_ready;
            tick();
        end
        cmd_in_valid = 0;
        if (!got) check("cmd_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic beats(input int n);
        for (int i = 0; i < n; i++) begin
            emif_rdata_valid = 1;
            emif_rdata = W'($urandom);
            if (i == 0) first_beat = emif_rdata;
            tick();
        end
        emif_rdata_valid = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        repeat (2) tick();
        rst = 0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst = 1; cmd_in_valid = 0; cmd_in_read = 0; cmd_in_burst = '0;
        cmd_out_ready = 1; emif_rdata_valid = 0; emif_rdata = '0; rsp_ready = 0;
        repeat (3) tick();
        rst = 0;
        tick();

        // Reset state
        @(negedge clk);
        check("reset_credits", 64'(credits), 64'd16);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_err_ovf", 64'(err_ovf), 64'd0);

        // Unsolicited beat
        tick();
        rsp_ready = 1;
        beats(1);
        @(negedge clk);
        check("spur_flag", 64'(err_spur), 64'd1);
        repeat (3) tick();

        // Single burst-4 read
        do_reset();
        send_cmd(1, 4, 10);
        @(negedge clk);
        check("single_credits", 64'(credits), 64'd12);
        tick();
        beats(4);
        repeat (3) tick();
        @(negedge clk);
        check("single_credits_back", 64'(credits), 64'd16);

        // Credit stall
        do_reset();
        rsp_ready = 0;
        send_cmd(1, 8, 10);
        send_cmd(1, 6, 10);
        fork
            send_cmd(1, 4, 60);
            begin
                @(negedge clk);
                check("stall_ready", 64'(cmd_in_ready), 64'd0);
                check("stall_out_valid", 64'(cmd_out_valid), 64'd0);
                tick();
                beats(2);
                @(negedge clk);
                check("stall_after_beats", 64'(cmd_in_ready), 64'd0);
                tick();
                rsp_ready = 1;
            end
        join
        beats(16);
        repeat (4) tick();
        @(negedge clk);
        check("stall_credits_back", 64'(credits), 64'd16);

        // Backpressure, fill, overflow, then back-to-back drain
        do_reset();
        rsp_ready = 0;
        send_cmd(1, 8, 10);
        send_cmd(1, 8, 10);
        @(negedge clk);
        check("bp_reserved_credits", 64'(credits), 64'd0);
        tick();
        beats(16);
        repeat (3) tick();
        @(negedge clk);
        check("bp_full_credits", 64'(credits), 64'd0);
        check("bp_head_held", 64'(rsp_data), 64'(exp_q.size() > 0 ? exp_q[0] : '0));
        tick();
        beats(1);
        @(negedge clk);
        check("ovf_flag", 64'(err_ovf), 64'd1);
        tick();
        rsp_ready = 1;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (rsp_valid) cnt++;
            tick();
        end
        check("bp_back_to_back", 64'(cnt), 64'd16);
        @(negedge clk);
        check("ovf_beat_absent", 64'(rsp_valid), 64'd0);
        tick();

        // Command accept, beat arrival and pop in one cycle
        do_reset();
        rsp_ready = 0;
        send_cmd(1, 2, 10);
        beats(1);
        @(negedge clk);
        check("simul_pre_credits", 64'(credits), 64'd14);
        tick();
        cmd_in_valid = 1; cmd_in_read = 1; cmd_in_burst = BW'(2);
        emif_rdata_valid = 1; emif_rdata = W'($urandom); rsp_ready = 1;
        @(negedge clk);
        check("simul_ready", 64'(cmd_in_ready), 64'd1);
        tick();
        cmd_in_valid = 0; emif_rdata_valid = 0; rsp_ready = 0;
        @(negedge clk);
        check("simul_post_credits", 64'(credits), 64'd13);
        tick();

        // Reset mid-burst
        do_reset();
        rsp_ready = 0;
        send_cmd(1, 5, 10);
        beats(2);
        cmd_in_valid = 1; cmd_in_read = 0; cmd_out_ready = 1;
        rst = 1;
        #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_credits", 64'(credits), 64'd16);
        check("rst_ready_held", 64'(cmd_in_ready), 64'd0);
        check("rst_out_valid_held", 64'(cmd_out_valid), 64'd0);
        cmd_in_valid = 0;
        repeat (2) tick();
        rst = 0;
        tick();
        cmd_in_valid = 1; cmd_in_read = 0;
        @(negedge clk);
        check("post_rst_write_ready", 64'(cmd_in_ready), 64'd1);
        tick();
        cmd_in_valid = 0;
        rsp_ready = 1;
        beats(1);
        @(negedge clk);
        check("post_rst_spur", 64'(err_spur), 64'd1);
        tick();

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cmd_in_valid     = ($urandom_range(0, 3) == 0);
            cmd_in_read      = ($urandom_range(0, 3) != 0);
            cmd_in_burst     = BW'($urandom);
            cmd_out_ready    = ($urandom_range(0, 3) != 0);
            rsp_ready        = ($urandom_range(0, 2) != 0);
            emif_rdata_valid = (m_out > 0) ? ($urandom_range(0, 1) == 1)
                                           : ($urandom_range(0, 99) == 0);
            emif_rdata       = W'($urandom);
            tick();
        end
        cmd_in_valid = 0; emif_rdata_valid = 0; rsp_ready = 1;
        tick();
        beats(m_out);
        repeat (20) tick();
        @(negedge clk);
        check("rand_drained_credits", 64'(credits), 64'd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
